// File: rtl/interval_meas_ctrl_pkg.sv
// Shared definitions for the interval measurement controller.
// Holds the FSM state encoding and the synchronizer depth floor.
// No ports; imported by the top and its sub-modules.
package interval_meas_ctrl_pkg;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_ARMED    = 2'd1;
    localparam logic [1:0] ST_COUNTING = 2'd2;
    localparam logic [1:0] ST_DONE     = 2'd3;

    localparam int SYNC_STAGES_MIN = 2;

    // A single flop is not a synchronizer, so any request below the floor
    // is raised to the floor rather than building an unsafe chain.
    function automatic int sync_stages_checked(input int n);
        return (n < SYNC_STAGES_MIN) ? SYNC_STAGES_MIN : n;
    endfunction

endpackage

// File: rtl/counter_ce.sv
// Cycle counter with synchronous clear, count enable and hold at all-ones.
// Latency: value updates on the edge after clr/en.
// Ports: clk, rst, clr, en -> cnt.
module counter_ce #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [WIDTH-1:0] cnt
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && !(&cnt)) begin
            // Holding at all-ones keeps a long interval from wrapping to a small value.
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/sync_edge.sv
// Synchronizes one asynchronous event level and emits a one-cycle pulse per rising edge.
// Latency: level sampled at edge k gives a pulse in cycle k+STAGES.
// Ports: clk, rst, evt (async level) -> pulse (one clk cycle).
module sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic evt,
    output logic pulse
);

    logic [STAGES-1:0] sync_q;
    logic              last_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            last_d <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], evt};
            last_d <= sync_q[STAGES-1];
        end
    end

    assign pulse = sync_q[STAGES-1] & ~last_d;

endmodule

// File: rtl/interval_meas_ctrl.sv
// Measures cycles between a start and a stop event, with arm/abort/timeout/saturation.
// Ports: arm/abort/result_ack control, start_evt/stop_evt async levels, timeout_lim;
//        result/result_valid/timeout latched result, busy/state/cnt_live status.
module interval_meas_ctrl
    import interval_meas_ctrl_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             arm,
    input  logic             abort,
    input  logic             start_evt,
    input  logic             stop_evt,
    input  logic [WIDTH-1:0] timeout_lim,
    input  logic             result_ack,
    output logic [WIDTH-1:0] result,
    output logic             result_valid,
    output logic             timeout,
    output logic             busy,
    output logic [1:0]       state,
    output logic [WIDTH-1:0] cnt_live
);

    localparam int NSYNC = sync_stages_checked(SYNC_STAGES);

    logic             start_p;
    logic             stop_p;
    logic [1:0]       state_n;
    logic             cnt_clr;
    logic             cnt_en;
    logic             res_ld;
    logic [WIDTH-1:0] res_nxt;
    logic             to_nxt;
    logic [WIDTH-1:0] cnt_p1;
    logic             cnt_max;
    logic             to_hit;

    sync_edge #(.STAGES(NSYNC)) u_sync_start (
        .clk   (clk),
        .rst   (rst),
        .evt   (start_evt),
        .pulse (start_p)
    );

    sync_edge #(.STAGES(NSYNC)) u_sync_stop (
        .clk   (clk),
        .rst   (rst),
        .evt   (stop_evt),
        .pulse (stop_p)
    );

    counter_ce #(.WIDTH(WIDTH)) u_cnt (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr),
        .en  (cnt_en),
        .cnt (cnt_live)
    );

    // cnt_p1 is what the counter will hold after this edge, so a stop seen
    // now reports the full start-to-stop sample distance.
    assign cnt_p1  = cnt_live + 1'b1;
    assign cnt_max = &cnt_live;
    assign to_hit  = (timeout_lim != '0) && (cnt_p1 == timeout_lim);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state logic
    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE: begin
                if (arm) state_n = ST_ARMED;
            end
            ST_ARMED: begin
                if (abort)        state_n = ST_IDLE;
                else if (start_p) state_n = ST_COUNTING;
            end
            ST_COUNTING: begin
                if (abort)                           state_n = ST_IDLE;
                else if (stop_p || to_hit || cnt_max) state_n = ST_DONE;
            end
            ST_DONE: begin
                if (result_ack) state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // Output / datapath control; priority abort > stop > timeout > saturation
    always_comb begin
        cnt_clr = 1'b0;
        cnt_en  = 1'b0;
        res_ld  = 1'b0;
        res_nxt = '0;
        to_nxt  = 1'b0;
        case (state)
            ST_ARMED: begin
                cnt_clr = abort | start_p;
            end
            ST_COUNTING: begin
                if (abort) begin
                    cnt_clr = 1'b1;
                end else begin
                    cnt_en = 1'b1;
                    if (stop_p) begin
                        res_ld  = 1'b1;
                        res_nxt = cnt_max ? '1 : cnt_p1;
                        to_nxt  = 1'b0;
                    end else if (to_hit) begin
                        res_ld  = 1'b1;
                        res_nxt = timeout_lim;
                        to_nxt  = 1'b1;
                    end else if (cnt_max) begin
                        res_ld  = 1'b1;
                        res_nxt = '1;
                        to_nxt  = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result       <= '0;
            timeout      <= 1'b0;
            result_valid <= 1'b0;
        end else begin
            if (res_ld) begin
                result  <= res_nxt;
                timeout <= to_nxt;
            end
            result_valid <= (state_n == ST_DONE);
        end
    end

    assign busy = (state == ST_ARMED) || (state == ST_COUNTING);

endmodule

// File: tb/tb_interval_meas_ctrl.sv
module tb_interval_meas_ctrl;

    localparam int W    = 8;
    localparam int NS   = 2;
    localparam int MAXV = (1 << W) - 1;

    logic         clk = 1'b0;
    logic         rst;
    logic         arm, abort, start_evt, stop_evt, result_ack;
    logic [W-1:0] timeout_lim;
    logic [W-1:0] result;
    logic         result_valid, timeout, busy;
    logic [1:0]   state;
    logic [W-1:0] cnt_live;

    interval_meas_ctrl #(.WIDTH(W), .SYNC_STAGES(NS)) dut (
        .clk          (clk),
        .rst          (rst),
        .arm          (arm),
        .abort        (abort),
        .start_evt    (start_evt),
        .stop_evt     (stop_evt),
        .timeout_lim  (timeout_lim),
        .result_ack   (result_ack),
        .result       (result),
        .result_valid (result_valid),
        .timeout      (timeout),
        .busy         (busy),
        .state        (state),
        .cnt_live     (cnt_live)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    bit cmp_en   = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Events are tracked as the sample-edge index at which each rising edge was
    // seen; the controller acts on it NS edges later.
    int m_state, m_cnt, m_result, m_to, cyc;
    int sq[$];
    int tq[$];
    bit p_start, p_stop;

    initial begin : model
        bit sp, tp;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_state = 0; m_cnt = 0; m_result = 0; m_to = 0; cyc = 0;
                sq.delete(); tq.delete(); p_start = 0; p_stop = 0;
            end else begin
                sp = 0; tp = 0;
                if (sq.size() > 0 && sq[0] == cyc) begin sp = 1; void'(sq.pop_front()); end
                if (tq.size() > 0 && tq[0] == cyc) begin tp = 1; void'(tq.pop_front()); end
                if (start_evt === 1'b1 && !p_start) sq.push_back(cyc + NS);
                if (stop_evt  === 1'b1 && !p_stop)  tq.push_back(cyc + NS);
                p_start = (start_evt === 1'b1);
                p_stop  = (stop_evt  === 1'b1);
                case (m_state)
                    0: if (arm) m_state = 1;
                    1: begin
                        if (abort)   begin m_state = 0; m_cnt = 0; end
                        else if (sp) begin m_state = 2; m_cnt = 0; end
                    end
                    2: begin
                        if (abort) begin
                            m_state = 0; m_cnt = 0;
                        end else if (tp) begin
                            m_cnt = (m_cnt + 1 > MAXV) ? MAXV : m_cnt + 1;
                            m_result = m_cnt; m_to = 0; m_state = 3;
                        end else if (timeout_lim != 0 && m_cnt + 1 == int'(timeout_lim)) begin
                            m_cnt = m_cnt + 1;
                            m_result = int'(timeout_lim); m_to = 1; m_state = 3;
                        end else if (m_cnt == MAXV) begin
                            m_result = MAXV; m_to = 1; m_state = 3;
                        end else begin
                            m_cnt = m_cnt + 1;
                        end
                    end
                    default: if (result_ack) m_state = 0;
                endcase
                cyc++;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(posedge clk) begin
        #2;
        if (cmp_en && !rst) begin
            chk("cyc_state",        state,        m_state);
            chk("cyc_busy",         busy,         (m_state == 1 || m_state == 2));
            chk("cyc_result_valid", result_valid, (m_state == 3));
            chk("cyc_result",       result,       m_result);
            chk("cyc_timeout",      timeout,      m_to);
            chk("cyc_cnt_live",     cnt_live,     m_cnt);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic wait_state(input logic [1:0] tgt, input int max, input string name, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (state !== tgt && n < max);
        if (state !== tgt) chk({"wait_", name}, state, tgt);
    endtask

    task automatic pulse_arm();
        arm = 1'b1; @(negedge clk); arm = 1'b0;
    endtask

    task automatic pulse_ack();
        result_ack = 1'b1; @(negedge clk); result_ack = 1'b0;
    endtask

    task automatic events_low();
        start_evt = 1'b0; stop_evt = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    int n;

    initial begin
        rst = 1'b1; arm = 0; abort = 0; start_evt = 0; stop_evt = 0;
        result_ack = 0; timeout_lim = '0;
        #12;
        chk("rst_state",        state,        0);
        chk("rst_result",       result,       0);
        chk("rst_result_valid", result_valid, 0);
        chk("rst_timeout",      timeout,      0);
        chk("rst_busy",         busy,         0);
        chk("rst_cnt_live",     cnt_live,     0);
        @(negedge clk);
        rst = 1'b0;
        cmp_en = 1'b1;
        repeat (2) @(negedge clk);

        // Basic interval of 100 cycles
        pulse_arm();
        chk("basic_armed", state, 1);
        start_evt = 1'b1;
        repeat (100) @(posedge clk);
        @(negedge clk);
        stop_evt = 1'b1;
        wait_state(3, 10, "basic_done", n);
        chk("basic_result",       result,   100);
        chk("basic_timeout",      timeout,  0);
        chk("basic_model_result", m_result, 100);
        repeat (3) @(negedge clk);
        chk("basic_valid_held", result_valid, 1);
        pulse_arm();
        chk("arm_in_done_ignored", state, 3);
        abort = 1'b1; @(negedge clk); abort = 1'b0;
        chk("abort_in_done_ignored", state, 3);
        pulse_ack();
        chk("basic_after_ack", state, 0);
        @(negedge clk);
        chk("basic_valid_low", result_valid, 0);
        pulse_ack();
        chk("ack_in_idle_ignored", state, 0);
        events_low();

        // Abort during counting
        pulse_arm();
        start_evt = 1'b1;
        wait_state(2, 10, "abort_counting", n);
        repeat (19) @(negedge clk);
        abort = 1'b1; @(negedge clk); abort = 1'b0;
        chk("abort_state",  state,        0);
        chk("abort_cnt",    cnt_live,     0);
        chk("abort_result", result,       100);
        chk("abort_valid",  result_valid, 0);
        events_low();

        // Timeout at 50
        timeout_lim = W'(50);
        pulse_arm();
        start_evt = 1'b1;
        wait_state(2, 10, "to_counting", n);
        wait_state(3, 100, "to_done", n);
        chk("to_cycles",       n,        50);
        chk("to_result",       result,   50);
        chk("to_flag",         timeout,  1);
        chk("to_model_result", m_result, 50);
        timeout_lim = '0;
        pulse_ack();
        events_low();

        // Start and stop together, then stop 30 cycles after start
        pulse_arm();
        start_evt = 1'b1; stop_evt = 1'b1;
        @(negedge clk);
        stop_evt = 1'b0;
        repeat (29) @(negedge clk);
        chk("simul_counting", state, 2);
        stop_evt = 1'b1;
        wait_state(3, 10, "simul_done", n);
        chk("simul_result",  result,  30);
        chk("simul_timeout", timeout, 0);
        pulse_ack();
        events_low();

        // Abort and stop pulse landing on the same edge
        pulse_arm();
        start_evt = 1'b1;
        wait_state(2, 10, "as_counting", n);
        repeat (5) @(negedge clk);
        stop_evt = 1'b1;
        repeat (2) @(negedge clk);
        abort = 1'b1; @(negedge clk); abort = 1'b0;
        chk("as_state",  state,        0);
        chk("as_valid",  result_valid, 0);
        chk("as_result", result,       30);
        repeat (2) @(negedge clk);
        chk("as_no_done", state, 0);
        events_low();

        // Saturation with no timeout
        pulse_arm();
        start_evt = 1'b1;
        wait_state(3, 400, "sat_done", n);
        chk("sat_result",  result,   MAXV);
        chk("sat_timeout", timeout,  1);
        repeat (5) @(negedge clk);
        chk("sat_cnt_hold", cnt_live, MAXV);
        pulse_ack();
        events_low();

        // Reset in the middle of counting
        pulse_arm();
        start_evt = 1'b1;
        wait_state(2, 10, "rst_counting", n);
        repeat (5) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midrst_state",   state,        0);
        chk("midrst_result",  result,       0);
        chk("midrst_timeout", timeout,      0);
        chk("midrst_valid",   result_valid, 0);
        chk("midrst_busy",    busy,         0);
        chk("midrst_cnt",     cnt_live,     0);
        start_evt = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        chk("post_rst_idle", state, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/interval_meas_ctrl.md
# interval_meas_ctrl

Sequences a WIDTH-bit cycle counter so that it measures the interval between a start event and a stop event. It supports arming, abort, timeout and saturation, and holds the result in a latched register behind a valid/ack handshake. It sits between the external event inputs and the 32-bit seven-segment display path: `cnt_live` drives the display while a measurement runs, and `result` drives it afterwards.

## Interface
- `WIDTH`, 32: counter, result and limit width.
- `SYNC_STAGES`, 2: synchronizer flops on `start_evt` and `stop_evt`. Minimum 2.
- `clk` in 1: single clock, all logic on the rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `arm` in 1: single-cycle request to arm. Honoured only in IDLE.
- `abort` in 1: cancels ARMED or COUNTING.
- `start_evt` in 1: asynchronous level. Its rising edge starts the count.
- `stop_evt` in 1: asynchronous level. Its rising edge stops the count.
- `timeout_lim` in WIDTH: maximum interval. 0 disables the timeout. Sampled on every cycle in COUNTING.
- `result_ack` in 1: consumer acknowledge.
- `result` out WIDTH: latched interval in clock cycles.
- `result_valid` out 1: high in DONE.
- `timeout` out 1: last result ended by timeout or saturation.
- `busy` out 1: high in ARMED or COUNTING.
- `state` out 2: IDLE=0, ARMED=1, COUNTING=2, DONE=3.
- `cnt_live` out WIDTH: current counter value.

## Operation
- **Event edge detection.** Each event passes through SYNC_STAGES flops. An edge pulse is formed as (last stage & ~delayed last stage): one cycle per rising edge.
- **IDLE → ARMED** on `arm`.
- **ARMED:**
  - Start pulse → COUNTING, and the counter is cleared to 0 on the same edge.
  - Stop pulses are ignored.
  - Start and stop pulses in the same cycle: start is taken, stop is ignored.
- **COUNTING:**
  - The counter increments every cycle.
  - Priority, highest first: abort, stop, timeout, saturation.
  - Stop pulse: `result <= cnt + 1`, `timeout <= 0`, → DONE.
  - Timeout: when `timeout_lim != 0` and `cnt + 1 == timeout_lim` with no stop, `result <= timeout_lim`, `timeout <= 1`, → DONE.
  - Saturation: when `cnt` reaches all-ones, the counter holds, `result <= all-ones`, `timeout <= 1`, → DONE. It never wraps.
- **Abort** in ARMED or COUNTING → IDLE. Counter cleared to 0. `result`, `timeout` and `result_valid` unchanged.
- **DONE:**
  - `result_valid = 1` and the counter holds its value.
  - `result_ack` → IDLE. `result` and `timeout` are retained until the next DONE entry.
  - `arm` and `abort` are ignored in DONE.
- `result_ack` outside DONE is ignored.
- `arm` in ARMED or COUNTING is ignored; no re-arm.

## Timing
- **Reset values.** Asserting `rst` immediately forces:
  - state IDLE;
  - counter, `result`, `timeout`, `result_valid`, `busy` = 0;
  - all synchronizer and edge flops = 0.
- **Reset mid-measurement:** the measurement is lost and no result is produced.
- **Event latency.** An event high at sampling edge k produces its pulse in cycle k+SYNC_STAGES. The FSM acts on the following edge.
- **Measured value.** Start and stop have equal latency, so `result` = (stop sampling edge − start sampling edge) in cycles.
- **Output latency.** `result_valid` rises one cycle after the stop pulse cycle and falls one cycle after the `result_ack` cycle.
- **Outputs are registered**, except `busy`, which is decoded from registered state.

## Structure
- The shared package or include holds:
  - the state encoding localparams;
  - the SYNC_STAGES minimum check.
- Sub-module `counter_ce`:
  - WIDTH-bit counter with synchronous clear, enable and saturate-hold;
  - asynchronous active-high reset.
- Synchronizer and edge detection are one instance per event, in sub-module `sync_edge`.

## Test plan
- **Basic interval:** arm, start_evt rising at edge 10, stop_evt rising at edge 110 → `result` = 100, `timeout` = 0, `result_valid` high until ack, then state IDLE.
- **Timeout:** `timeout_lim` = 50, start with no stop → `result` = 50, `timeout` = 1, DONE entered 50 cycles after the start pulse cycle.
- **Abort:** abort at the 20th COUNTING cycle → IDLE, `cnt_live` = 0; the previous `result` of 100 is unchanged.
- **Simultaneous events:**
  - start and stop together in ARMED → COUNTING, then stop 30 cycles later → `result` = 30;
  - abort and stop in the same cycle → IDLE, no result.
- **Saturation:** WIDTH = 8, `timeout_lim` = 0, no stop → `result` = 255, `timeout` = 1, counter holds at 255.
- **Reset mid-COUNTING and ignored controls:**
  - `rst` mid-COUNTING → all outputs 0 immediately;
  - `arm` in DONE and `result_ack` in IDLE cause no state change.
